// File: rtl/seq_alu_if.sv
// Operand/result bundle between the A09 control sequencer and the clocked ALU.
interface seq_alu_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLAG_BITS  = 4
);
  logic                  start;
  logic [3:0]            func_op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  load_flags;
  logic [FLAG_BITS-1:0]  flags_in;
  logic [DATA_WIDTH-1:0] y;
  logic [DATA_WIDTH-1:0] y_hi;
  logic [FLAG_BITS-1:0]  flags;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, func_op, a, b, load_flags, flags_in,
    input  y, y_hi, flags, busy, done, err
  );

  modport slave (
    input  start, func_op, a, b, load_flags, flags_in,
    output y, y_hi, flags, busy, done, err
  );
endinterface

// File: rtl/seq_alu.sv
// Clocked ALU with persistent VNCZ flags and a shift-add multiplier that
// takes one partial product per clock.
module seq_alu #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FLAG_BITS  = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  seq_alu_if.slave  bus
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADC = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_ROL = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t             r_state;
  logic [W-1:0]       r_y;
  logic [W-1:0]       r_y_hi;
  logic [FLAG_BITS-1:0] r_flags;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [2*W-1:0]     r_acc;
  logic [2*W-1:0]     r_mcand;
  logic [W-1:0]       r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic [W-1:0]       w_opb;
  logic               w_cin;
  logic [W:0]         w_sum;
  logic [W-1:0]       w_res;
  logic [W-1:0]       w_y;
  logic               w_c;
  logic               w_v;
  logic               w_legal;
  logic [FLAG_BITS-1:0] w_flags;
  logic [2*W-1:0]     w_acc_next;
  logic [FLAG_BITS-1:0] w_mul_flags;

  // Single-cycle datapath; subtraction forms A + ~B + carry so C=1 means no borrow.
  always_comb begin
    w_opb = bus.b;
    w_cin = 1'b0;
    case (bus.func_op)
      OP_SUB, OP_CMP: begin w_opb = ~bus.b; w_cin = 1'b1;       end
      OP_ADC:         begin w_opb = bus.b;  w_cin = r_flags[1]; end
      OP_SBC:         begin w_opb = ~bus.b; w_cin = r_flags[1]; end
      default:        ;
    endcase
    w_sum   = {1'b0, bus.a} + {1'b0, w_opb} + (W+1)'(w_cin);
    w_res   = w_sum[W-1:0];
    w_c     = w_sum[W];
    w_v     = 1'b0;
    w_legal = 1'b1;
    case (bus.func_op)
      OP_ADD, OP_ADC: w_v = (bus.a[W-1] == bus.b[W-1]) && (w_res[W-1] != bus.a[W-1]);
      OP_SUB, OP_SBC, OP_CMP:
                      w_v = (bus.a[W-1] != bus.b[W-1]) && (w_res[W-1] != bus.a[W-1]);
      OP_AND: begin w_res = bus.a & bus.b; w_c = 1'b0; end
      OP_OR:  begin w_res = bus.a | bus.b; w_c = 1'b0; end
      OP_XOR: begin w_res = bus.a ^ bus.b; w_c = 1'b0; end
      OP_SHL: begin w_res = {bus.a[W-2:0], 1'b0};        w_c = bus.a[W-1]; end
      OP_SHR: begin w_res = {1'b0, bus.a[W-1:1]};        w_c = bus.a[0];   end
      OP_ASR: begin w_res = {bus.a[W-1], bus.a[W-1:1]};  w_c = bus.a[0];   end
      OP_ROL: begin w_res = {bus.a[W-2:0], bus.a[W-1]};  w_c = bus.a[W-1]; end
      OP_MUL: ;
      default: w_legal = 1'b0;
    endcase
    // CMP reports the difference in its flags but passes A through.
    w_y        = (bus.func_op == OP_CMP) ? bus.a : w_res;
    w_flags    = '0;
    w_flags[3] = w_v;
    w_flags[2] = w_res[W-1];
    w_flags[1] = w_c;
    w_flags[0] = (w_res == '0);
  end

  always_comb begin
    w_acc_next     = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_flags    = '0;
    w_mul_flags[2] = w_acc_next[2*W-1];
    w_mul_flags[1] = (w_acc_next[2*W-1:W] != '0);
    w_mul_flags[0] = (w_acc_next == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_y      <= '0;
      r_y_hi   <= '0;
      r_flags  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && bus.func_op == OP_MUL) begin
            r_state  <= ST_MUL;
            r_busy   <= 1'b1;
            r_acc    <= '0;
            r_mcand  <= {W'(0), bus.a};
            r_mplier <= bus.b;
            r_cnt    <= CNT_W'(W);
            if (bus.load_flags) r_flags <= bus.flags_in;
          end else if (bus.start && w_legal) begin
            r_y     <= w_y;
            r_y_hi  <= '0;
            r_flags <= w_flags;
            r_done  <= 1'b1;
          end else if (bus.start) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            if (bus.load_flags) r_flags <= bus.flags_in;
          end else if (bus.load_flags) begin
            r_flags <= bus.flags_in;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_y     <= w_acc_next[W-1:0];
            r_y_hi  <= w_acc_next[2*W-1:W];
            r_flags <= w_mul_flags;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.y     = r_y;
  assign bus.y_hi  = r_y_hi;
  assign bus.flags = r_flags;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu with hand-computed results.
module tb_seq_alu;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  seq_alu_if #(.DATA_WIDTH(8), .FLAG_BITS(4)) bus ();

  seq_alu #(.DATA_WIDTH(8), .FLAG_BITS(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one Start for a single edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.start   = 1'b1;
    bus.func_op = op;
    bus.a       = a;
    bus.b       = b;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.func_op = 4'b0000;
    bus.a       = 8'h5A;
    bus.b       = 8'hA5;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ey, input logic [3:0] ef);
    issue(op, a, b);
    check({tag, ".done"},  32'(bus.done), 32'd1);
    check({tag, ".y"},     32'(bus.y), 32'(ey));
    check({tag, ".flags"}, 32'(bus.flags), 32'(ef));
    check({tag, ".yhi"},   32'(bus.y_hi), 32'd0);
    check({tag, ".busy"},  32'(bus.busy), 32'd0);
    check({tag, ".err"},   32'(bus.err), 32'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ey, input logic [7:0] ehi, input logic [3:0] ef,
                         input bit inject);
    int lat;
    int busy_drops;
    lat = 0;
    busy_drops = 0;
    issue(4'b1100, a, b);
    check({tag, ".busy0"}, 32'(bus.busy), 32'd1);
    check({tag, ".done0"}, 32'(bus.done), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      if (inject && k == 3) begin
        bus.start = 1'b1; bus.func_op = 4'b0000; bus.a = 8'h01; bus.b = 8'h01;
        bus.load_flags = 1'b1; bus.flags_in = 4'b1111;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.load_flags = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_drops++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".busy_gap"}, 32'(busy_drops), 32'd0);
    check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
    check({tag, ".y"},     32'(bus.y), 32'(ey));
    check({tag, ".yhi"},   32'(bus.y_hi), 32'(ehi));
    check({tag, ".flags"}, 32'(bus.flags), 32'(ef));
    idle_cycle();
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.func_op = 4'b0000; bus.a = 8'h00; bus.b = 8'h00;
    bus.load_flags = 1'b0; bus.flags_in = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.y",     32'(bus.y), 32'd0);
    check("rst.yhi",   32'(bus.y_hi), 32'd0);
    check("rst.flags", 32'(bus.flags), 32'd0);
    check("rst.busy",  32'(bus.busy), 32'd0);
    check("rst.done",  32'(bus.done), 32'd0);
    check("rst.err",   32'(bus.err), 32'd0);
    rst_n = 1'b1;
    idle_cycle();

    single("add_ovf", 4'b0000, 8'h7F, 8'h01, 8'h80, 4'b1100);
    idle_cycle();
    check("add.done_pulse", 32'(bus.done), 32'd0);
    check("add.y_hold", 32'(bus.y), 32'h80);

    // Back-to-back: SUB, ADC (uses C=1), then SBC with C cleared.
    single("sub_zero", 4'b0001, 8'h05, 8'h05, 8'h00, 4'b0011);
    single("adc_cin",  4'b0010, 8'hFF, 8'h00, 8'h00, 4'b0011);
    bus.load_flags = 1'b1; bus.flags_in = 4'b0000;
    idle_cycle();
    bus.load_flags = 1'b0;
    check("ld0.flags", 32'(bus.flags), 32'd0);
    single("sbc_borrow", 4'b0101, 8'h00, 8'h01, 8'hFE, 4'b0100);
    single("sub_ovf", 4'b0001, 8'h80, 8'h01, 8'h7F, 4'b1010);
    single("cmp", 4'b0111, 8'h03, 8'h05, 8'h03, 4'b0100);
    single("and", 4'b0011, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    single("or",  4'b0100, 8'h80, 8'h01, 8'h81, 4'b0100);
    single("xor", 4'b0110, 8'hAA, 8'hAA, 8'h00, 4'b0001);
    single("shl", 4'b1000, 8'h81, 8'h00, 8'h02, 4'b0010);
    single("shr", 4'b1001, 8'h01, 8'h00, 8'h00, 4'b0011);
    single("asr", 4'b1010, 8'h80, 8'h00, 8'hC0, 4'b0100);
    idle_cycle();

    run_mul("mul_ff",   8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110, 1'b0);
    run_mul("mul_0f11", 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0000, 1'b0);
    run_mul("mul_inj",  8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0110, 1'b1);

    // Reset in the middle of a multiply aborts it without a Done.
    issue(4'b1100, 8'h0F, 8'h11);
    idle_cycle();
    idle_cycle();
    rst_n = 1'b0;
    idle_cycle();
    check("mrst.y",     32'(bus.y), 32'd0);
    check("mrst.yhi",   32'(bus.y_hi), 32'd0);
    check("mrst.flags", 32'(bus.flags), 32'd0);
    check("mrst.busy",  32'(bus.busy), 32'd0);
    check("mrst.done",  32'(bus.done), 32'd0);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      idle_cycle();
      if (bus.done) seen_done++;
    end
    check("mrst.no_done", 32'(seen_done), 32'd0);

    // Illegal opcode leaves Y and flags untouched.
    single("add_pre", 4'b0000, 8'h7F, 8'h01, 8'h80, 4'b1100);
    bus.load_flags = 1'b1; bus.flags_in = 4'b0011;
    idle_cycle();
    bus.load_flags = 1'b0;
    check("ld3.flags", 32'(bus.flags), 32'h3);
    issue(4'b1110, 8'h12, 8'h34);
    check("ill.done",  32'(bus.done), 32'd1);
    check("ill.err",   32'(bus.err), 32'd1);
    check("ill.y",     32'(bus.y), 32'h80);
    check("ill.flags", 32'(bus.flags), 32'h3);
    idle_cycle();
    check("ill.err_pulse", 32'(bus.err), 32'd0);

    bus.load_flags = 1'b1; bus.flags_in = 4'b0010;
    idle_cycle();
    bus.load_flags = 1'b0;
    check("ld2.flags", 32'(bus.flags), 32'h2);
    single("rol", 4'b1011, 8'h81, 8'h00, 8'h03, 4'b0010);

    // ADD completing on the same edge as LoadFlags wins.
    bus.load_flags = 1'b1; bus.flags_in = 4'b1111;
    single("add_vs_ld", 4'b0000, 8'h01, 8'h01, 8'h02, 4'b0000);
    bus.load_flags = 1'b0;
    idle_cycle();
    check("add_vs_ld.hold", 32'(bus.flags), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, clocked ALU that extends the combinational 4-bit-op ALU with registered results, a persistent VNCZ flags register, carry-in ops, shifts/rotates and a multi-cycle unsigned multiply. It sits between the register file and the writeback mux of the A09 datapath. A Start/Busy/Done handshake lets the control sequencer stall on multi-cycle ops.

## Interface
- DataWidth, 8, operand/result width (≥4).
- FlagBits, 4, flag register width; bit order fixed: V=3, N=2, C=1, Z=0.
- Clk  input  1  rising-edge clock.
- Reset_N  input  1  synchronous, active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- FuncOp  input  4  operation code, sampled with Start.
- A, B  input  DataWidth  operands, sampled with Start.
- LoadFlags  input  1  overwrite flags register with FlagsIn.
- FlagsIn  input  FlagBits  value for LoadFlags.
- Y  output  DataWidth  registered result (low half for MUL).
- YHi  output  DataWidth  registered high half of MUL product; 0 after any other op.
- Flags  output  FlagBits  flags register.
- Busy  output  1  multi-cycle op in progress.
- Done  output  1  one-cycle pulse: Y/YHi/Flags updated this cycle.
- Err  output  1  one-cycle pulse with Done for illegal FuncOp.

## Operation
- Reset (Reset_N=0 at edge): Y=0, YHi=0, Flags=0, Busy=0, Done=0, Err=0, state IDLE. Reset mid-MUL aborts; no Done.
- States: IDLE, MUL. IDLE+Start+MUL → MUL; MUL with step counter = DataWidth, decrementing; last step → IDLE.
- Opcodes (Cin = Flags[C]): 0000 ADD A+B; 0001 SUB A+~B+1; 0010 ADC A+B+Cin; 0011 AND; 0100 OR; 0101 SBC A+~B+Cin; 0110 XOR; 0111 CMP (SUB flags, Y = A); 1000 SHL (C=A[msb], lsb 0); 1001 SHR (C=A[0], msb 0); 1010 ASR (C=A[0], msb kept); 1011 ROL (C=A[msb]); 1100 MUL unsigned A*B; 1101–1111 illegal.
- Arithmetic done at DataWidth+1 bits; C = bit DataWidth (SUB/SBC/CMP: C=1 means no borrow).
- V: ADD/ADC: A,B same sign and Y sign differs. SUB/SBC/CMP: A,B signs differ and Y sign ≠ A sign. Logic/shift ops: V=0, C=0 for AND/OR/XOR.
- N = Y[msb], Z = (Y==0) for all non-MUL ops.
- MUL: shift-add, one partial product per cycle; N = product[2*DataWidth-1], Z = (product==0), C = (YHi≠0), V=0.
- Illegal op: Y, YHi, Flags unchanged; Done=1, Err=1.
- Start while Busy=1: ignored, not queued.
- LoadFlags: Flags←FlagsIn next edge if Busy=0 and no op completes that edge; if an op completes the same edge, op flags win and LoadFlags is dropped. LoadFlags while Busy=1: ignored.
- ADC/SBC use Flags[C] as registered at Start edge.

## Timing
- Single-cycle ops: Start at edge N → Y/Flags valid and Done=1 during cycle after edge N; Busy stays 0; new Start accepted in the Done cycle (back-to-back throughput 1/clk).
- MUL: Start at edge N → Busy=1 from edge N through edge N+DataWidth-1; at edge N+DataWidth, Y/YHi/Flags update, Done=1, Busy=0. Latency DataWidth cycles.
- Y, YHi, Flags hold between ops. Done/Err high exactly one cycle.
- A, B, FuncOp need only be valid at the Start edge.

## Test plan
- Reset then ADD A=0x7F B=0x01 → next cycle Y=0x80, Flags=4'b1100, Done=1 one cycle, Busy=0.
- SUB A=0x05 B=0x05 → Y=0x00, Flags=4'b0011; then ADC A=0xFF B=0x00 (C=1) → Y=0x00, Flags=4'b0011; SBC A=0x00 B=0x01 with C=0 → Y=0xFE, Flags=4'b0100.
- MUL A=0xFF B=0xFF → Busy 8 cycles, Done at N+8, Y=0x01, YHi=0xFE, Flags=4'b0110; MUL 0x0F×0x11 → Y=0xFF, YHi=0x00, Flags=4'b0000.
- During MUL pulse Start(ADD) and LoadFlags=4'b1111 → both ignored, MUL result exact; assert Reset_N=0 mid-second MUL → all outputs 0, no Done.
- FuncOp=4'b1110 after flags=4'b0011 → Done=1, Err=1, Y and Flags unchanged.
- LoadFlags FlagsIn=4'b0010 idle → Flags=4'b0010; ROL A=0x81 → Y=0x03, Flags=4'b0010; LoadFlags with ADD completing same edge → ADD flags.
